// File: rtl/prog_imem_pkg.sv
// prog_imem_pkg: shared types and helpers for the loadable instruction memory.
package prog_imem_pkg;

  // Controller states: fill with HALT, idle/serving, streaming a program in.
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_READY = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  // Opcode field of the HALT instruction (top six bits of the fill word).
  localparam logic [5:0] HALT_OPCODE = 6'b111111;

  // Bank-select width: at least one bit, even for a single bank.
  function automatic int bank_w_f(input int banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

endpackage

// File: rtl/imem_bank_ram.sv
// imem_bank_ram: one program bank. Single address port, synchronous write,
// registered read. The read register only updates on a read strobe, so the
// last fetched word stays on o_rdata between fetches.
module imem_bank_ram #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WIDTH-1:0]  i_wdata,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [0:(1 << ADDR_W) - 1];

  // Storage write; contents are not reset, the controller refills them.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Registered read port, cleared by reset so fetch data starts at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_rdata <= '0;
    end else if (i_re) begin
      o_rdata <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/prog_imem.sv
// prog_imem: multi-bank instruction memory with a streaming load port and a
// latency-1 fetch port. After reset every word of every bank holds HALT.
// Optional feature macro: PROG_IMEM_PARITY_EN adds a stored even-parity bit
// per word and the o_fetch_perr output.
module prog_imem
  import prog_imem_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 7,
  parameter int          BANKS     = 2,
  parameter logic [31:0] HALT_WORD = 32'hFC00_0000,
  parameter int          BANK_W    = bank_w_f(BANKS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BANK_W-1:0] i_bank_sel,
  input  logic              i_fetch_req,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic [DATA_W-1:0] o_fetch_data,
  output logic              o_fetch_valid,
  input  logic [BANK_W-1:0] i_load_bank,
  input  logic              i_load_valid,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_load_last,
  output logic              o_load_ready,
  output logic              o_load_done,
  output logic              o_load_err,
  output logic              o_busy
`ifdef PROG_IMEM_PARITY_EN
  ,
  output logic              o_fetch_perr
`endif
);

`ifdef PROG_IMEM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int WORD_W = DATA_W + PAR_W;
  localparam logic [DATA_W-1:0] HALT_FILL = DATA_W'(HALT_WORD);

  // Stored word image: data, plus its even-parity bit when enabled.
  function automatic logic [WORD_W-1:0] word_f(input logic [DATA_W-1:0] d);
`ifdef PROG_IMEM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  state_t              r_state;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic [ADDR_W:0]     r_ld_ptr;    // MSB set means the bank is full
  logic [BANK_W-1:0]   r_ld_bank;
  logic [BANK_W-1:0]   r_rd_bank;   // bank whose read register feeds o_fetch_data

  logic [BANK_W-1:0]   w_fsel;
  logic [BANK_W-1:0]   w_lsel;
  logic                w_accept;
  logic                w_fetch_ok;
  logic [BANKS-1:0]    w_we;
  logic [BANKS-1:0]    w_re;
  logic [ADDR_W-1:0]   w_waddr [BANKS];
  logic [ADDR_W-1:0]   w_addr  [BANKS];
  logic [WORD_W-1:0]   w_wdata [BANKS];
  logic [WORD_W-1:0]   w_rdata [BANKS];

  // With a single bank the select inputs carry no information.
  assign w_fsel   = (BANKS == 1) ? '0 : i_bank_sel;
  assign w_lsel   = (BANKS == 1) ? '0 : i_load_bank;
  assign w_accept = i_load_valid & o_load_ready;

  // Per-bank write control: HALT fill during CLEAR, load beats otherwise.
  always_comb begin
    for (int b = 0; b < BANKS; b++) begin
      w_we[b]    = 1'b0;
      w_waddr[b] = '0;
      w_wdata[b] = word_f(HALT_FILL);
      case (r_state)
        ST_CLEAR: begin
          w_we[b]    = 1'b1;
          w_waddr[b] = r_clr_cnt;
        end
        ST_READY: begin
          if (w_accept && (w_lsel == BANK_W'(b))) begin
            w_we[b]    = 1'b1;
            w_wdata[b] = word_f(i_load_data);
          end else begin
            w_we[b]    = 1'b0;
          end
        end
        ST_LOAD: begin
          if (w_accept && (r_ld_bank == BANK_W'(b)) && !r_ld_ptr[ADDR_W]) begin
            w_we[b]    = 1'b1;
            w_waddr[b] = r_ld_ptr[ADDR_W-1:0];
            w_wdata[b] = word_f(i_load_data);
          end else begin
            w_we[b]    = 1'b0;
          end
        end
        default: begin
          w_we[b] = 1'b0;
        end
      endcase
    end
  end

  // Fetch arbitration: a bank being loaded or written this cycle cannot be read.
  always_comb begin
    w_fetch_ok = 1'b0;
    if (!i_fetch_req || (r_state == ST_CLEAR) || (int'(w_fsel) >= BANKS)) begin
      w_fetch_ok = 1'b0;
    end else if ((r_state == ST_LOAD) && (w_fsel == r_ld_bank)) begin
      w_fetch_ok = 1'b0;
    end else if (w_we[w_fsel]) begin
      w_fetch_ok = 1'b0;
    end else begin
      w_fetch_ok = 1'b1;
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    assign w_re[b]   = w_fetch_ok && (w_fsel == BANK_W'(b));
    assign w_addr[b] = w_we[b] ? w_waddr[b] : i_fetch_addr;

    imem_bank_ram #(
      .WIDTH  (WORD_W),
      .ADDR_W (ADDR_W)
    ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .i_we    (w_we[b]),
      .i_re    (w_re[b]),
      .i_addr  (w_addr[b]),
      .i_wdata (w_wdata[b]),
      .o_rdata (w_rdata[b])
    );
  end

  // Read registers live in the banks; the select is registered alongside them.
  assign o_fetch_data = w_rdata[r_rd_bank][DATA_W-1:0];

`ifdef PROG_IMEM_PARITY_EN
  // Even parity over data plus stored bit is zero for an intact word.
  assign o_fetch_perr = o_fetch_valid & (^w_rdata[r_rd_bank]);
`endif

  // Controller FSM: clear sweep, load handshake, sticky overflow, fetch valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_CLEAR;
      r_clr_cnt     <= '0;
      r_ld_ptr      <= '0;
      r_ld_bank     <= '0;
      r_rd_bank     <= '0;
      o_fetch_valid <= 1'b0;
      o_load_ready  <= 1'b0;
      o_load_done   <= 1'b0;
      o_load_err    <= 1'b0;
      o_busy        <= 1'b1;
    end else begin
      o_load_done   <= 1'b0;
      o_fetch_valid <= w_fetch_ok;
      if (w_fetch_ok) begin
        r_rd_bank <= w_fsel;
      end
      case (r_state)
        ST_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
          if (r_clr_cnt == {ADDR_W{1'b1}}) begin
            r_state      <= ST_READY;
            o_busy       <= 1'b0;
            o_load_ready <= 1'b1;
          end
        end
        ST_READY: begin
          if (w_accept) begin
            r_ld_bank <= w_lsel;
            r_ld_ptr  <= (ADDR_W+1)'(1);
            if (i_load_last) begin
              o_load_done <= 1'b1;
            end else begin
              r_state <= ST_LOAD;
              o_busy  <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            if (r_ld_ptr[ADDR_W]) begin
              o_load_err <= 1'b1;
            end else begin
              r_ld_ptr <= r_ld_ptr + (ADDR_W+1)'(1);
            end
            if (i_load_last) begin
              r_state     <= ST_READY;
              o_load_done <= 1'b1;
              o_busy      <= 1'b0;
            end
          end
        end
        default: begin
          r_state      <= ST_CLEAR;
          r_clr_cnt    <= '0;
          o_load_ready <= 1'b0;
          o_busy       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_imem.sv
// tb_prog_imem: directed bench for prog_imem (2 banks x 128 words x 32 bits)
// with a reference model of the memory contents and handshake outputs.
module tb_prog_imem;

  localparam logic [31:0] HALT = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [0:0]  bank_sel = 1'b0;
  logic        fetch_req = 1'b0;
  logic [6:0]  fetch_addr = 7'd0;
  logic [31:0] fetch_data;
  logic        fetch_valid;
  logic [0:0]  load_bank = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = 32'd0;
  logic        load_last = 1'b0;
  logic        load_ready, load_done, load_err, busy;
`ifdef PROG_IMEM_PARITY_EN
  logic        fetch_perr;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  prog_imem #(.DATA_W(32), .ADDR_W(7), .BANKS(2), .HALT_WORD(32'hFC00_0000)) dut (
    .clk(clk), .reset(reset),
    .i_bank_sel(bank_sel), .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr),
    .o_fetch_data(fetch_data), .o_fetch_valid(fetch_valid),
    .i_load_bank(load_bank), .i_load_valid(load_valid), .i_load_data(load_data),
    .i_load_last(load_last), .o_load_ready(load_ready), .o_load_done(load_done),
    .o_load_err(load_err), .o_busy(busy)
`ifdef PROG_IMEM_PARITY_EN
    , .o_fetch_perr(fetch_perr)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem [2][128];
  int          m_clear_left = 0;
  bit          m_loading = 1'b0;
  int          m_ld_bank = 0;
  int          m_ptr = 0;
  bit          m_live = 1'b0;
  logic [31:0] e_data = 32'd0;
  logic        e_valid = 1'b0, e_done = 1'b0, e_err = 1'b0, e_busy = 1'b1, e_ready = 1'b0;

  // Model advances on each rising edge from the inputs present at that edge.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_clear_left = 128; m_loading = 1'b0; e_err = 1'b0;
        e_valid = 1'b0; e_data = 32'd0; e_done = 1'b0; e_busy = 1'b1; e_ready = 1'b0;
        m_live = 1'b1;
      end else begin
        e_done  = 1'b0;
        e_valid = fetch_req && (m_clear_left == 0) &&
                  !(m_loading && (int'(bank_sel) == m_ld_bank));
        if (e_valid) e_data = m_mem[bank_sel][fetch_addr];
        if (m_clear_left > 0) begin
          for (int b = 0; b < 2; b++) m_mem[b][128 - m_clear_left] = HALT;
          m_clear_left--;
        end else if (load_valid) begin
          if (!m_loading) begin
            m_ld_bank = int'(load_bank);
            m_mem[m_ld_bank][0] = load_data;
            m_ptr = 1;
            if (load_last) e_done = 1'b1; else m_loading = 1'b1;
          end else begin
            if (m_ptr < 128) begin
              m_mem[m_ld_bank][m_ptr] = load_data;
              m_ptr++;
            end else begin
              e_err = 1'b1;
            end
            if (load_last) begin m_loading = 1'b0; e_done = 1'b1; end
          end
        end
        e_busy  = (m_clear_left > 0) || m_loading;
        e_ready = (m_clear_left == 0);
      end
    end
  end

  // Every cycle: compare all observable outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, e_valid});
        chk("fetch_data", fetch_data, e_data);
        chk("busy", {31'd0, busy}, {31'd0, e_busy});
        chk("load_ready", {31'd0, load_ready}, {31'd0, e_ready});
        chk("load_done", {31'd0, load_done}, {31'd0, e_done});
        chk("load_err", {31'd0, load_err}, {31'd0, e_err});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_chk(input logic [0:0] b, input logic [6:0] a,
                           input logic [31:0] exp, input string name);
    bank_sel = b; fetch_addr = a; fetch_req = 1'b1;
    tick();
    chk({name, "_valid"}, {31'd0, fetch_valid}, 32'd1);
    chk(name, fetch_data, exp);
    fetch_req = 1'b0;
  endtask

  task automatic beat(input logic [0:0] b, input logic [31:0] d, input logic last);
    int n = 0;
    while (!load_ready && n < 500) begin n++; tick(); end
    chk("ready_timeout", {31'd0, load_ready}, 32'd1);
    load_bank = b; load_data = d; load_last = last; load_valid = 1'b1;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin n++; tick(); end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    repeat (3) tick();
    reset = 1'b0;

    // Clear sweep: busy for exactly 128 cycles after release.
    n = 0;
    while (busy && n < 1000) begin n++; tick(); end
    chk("busy_cycles", 32'(n), 32'd128);
    fetch_chk(1'b0, 7'd5, 32'hFC00_0000, "halt_b0");
    fetch_chk(1'b1, 7'd100, 32'hFC00_0000, "halt_b1");

    // Three-beat program into bank 1.
    beat(1'b1, 32'h8C09_0000, 1'b0);
    beat(1'b1, 32'h8C0A_0001, 1'b0);
    beat(1'b1, 32'h012A_4822, 1'b1);
    chk("done_3beat", {31'd0, load_done}, 32'd1);
    tick();
    chk("done_is_pulse", {31'd0, load_done}, 32'd0);
    fetch_chk(1'b1, 7'd2, 32'h012A_4822, "prog_b1_a2");
    fetch_chk(1'b1, 7'd3, 32'hFC00_0000, "prog_b1_a3");
    fetch_chk(1'b1, 7'd0, 32'h8C09_0000, "prog_b1_a0");

    // Fetches while bank 1 is loading.
    beat(1'b1, 32'h1111_1111, 1'b0);
    fetch_chk(1'b0, 7'd0, 32'hFC00_0000, "side_b0");
    bank_sel = 1'b1; fetch_addr = 7'd0; fetch_req = 1'b1;
    tick();
    chk("blocked_b1_valid", {31'd0, fetch_valid}, 32'd0);
    chk("blocked_hold_data", fetch_data, 32'hFC00_0000);
    fetch_req = 1'b0;
    beat(1'b1, 32'h2222_2222, 1'b1);
    chk("done_2beat", {31'd0, load_done}, 32'd1);
    fetch_chk(1'b1, 7'd0, 32'h1111_1111, "reload_b1_a0");
    fetch_chk(1'b1, 7'd1, 32'h2222_2222, "reload_b1_a1");
    fetch_chk(1'b1, 7'd2, 32'h012A_4822, "reload_b1_a2");

    // Overflow: 130 beats into bank 0.
    for (int i = 0; i < 130; i++) begin
      beat(1'b0, 32'hA000_0000 + 32'(i), (i == 129));
      if (i == 127) chk("err_before_overflow", {31'd0, load_err}, 32'd0);
      if (i == 128) chk("err_after_beat129", {31'd0, load_err}, 32'd1);
    end
    chk("done_130", {31'd0, load_done}, 32'd1);
    fetch_chk(1'b0, 7'd127, 32'hA000_007F, "ovf_b0_a127");
    fetch_chk(1'b0, 7'd0, 32'hA000_0000, "ovf_b0_a0");
    reset = 1'b1;
    tick();
    chk("err_cleared", {31'd0, load_err}, 32'd0);
    chk("busy_in_reset", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    wait_idle();

    // Reset in the middle of a load.
    for (int i = 0; i < 5; i++) beat(1'b1, 32'h5500_0000 + 32'(i), 1'b0);
    load_bank = 1'b1; load_data = 32'h5500_0005; load_valid = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0; load_valid = 1'b0;
    wait_idle();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      fetch_chk(iv[7], iv[6:0], 32'hFC00_0000, "sweep_halt");
    end

`ifdef PROG_IMEM_PARITY_EN
    dut.g_bank[0].u_ram.r_mem[4][32] = ~dut.g_bank[0].u_ram.r_mem[4][32];
    fetch_chk(1'b0, 7'd4, 32'hFC00_0000, "perr_a4_data");
    chk("perr_a4", {31'd0, fetch_perr}, 32'd1);
    fetch_chk(1'b0, 7'd5, 32'hFC00_0000, "perr_a5_data");
    chk("perr_a5", {31'd0, fetch_perr}, 32'd0);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
